mt9d111_i2c_config: RTL and testbench
=====================================

Name: mt9d111_i2c_config

Overview:
- Upstream configuration stage for the MT9D111 capture path.
- After reset, and after a fixed power-up delay, it walks a register table and writes each entry to the camera over two-wire I2C. Each write is: device address, 8-bit register address, 16-bit data, MSB first.
- Puts the sensor into 320x240 YCbCr 4:2:2 mode before the pixel capture block starts consuming data.
- Runs entirely on clk_50; the bus lines are open-drain, and this block only ever drives them low.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- I2C_HZ, 100000, SCL frequency. QTR = CLK_HZ/(4*I2C_HZ) = 125 cycles per quarter bit.
- DEV_ADDR, 8'hBA, 7-bit address plus write bit (R/W=0).
- NUM_REGS, 16, number of table entries.
- PWRUP_CYCLES, 50000, delay after reset before the first write (1 ms).
- GAP_CYCLES, 500, idle time between consecutive writes.

Ports:
- clk_50  in  1  system clock.
- reset  in  1  reset, synchronous, active-high; clock clk_50.
- start  in  1  one-cycle pulse that reruns the table; ignored while busy.
- scl_oe  out  1  1 = pull SCL low; 0 = release.
- sda_oe  out  1  1 = pull SDA low; 0 = release.
- sda_in  in  1  sampled SDA (top level provides a two-flop synchroniser).
- busy  out  1  sequence in progress.
- done  out  1  level; the whole table was written with every ACK received.
- ack_error  out  1  level; a NACK aborted the sequence.
- reg_index  out  log2(NUM_REGS)  index of the current or last entry.

Behaviour:
- Reset values:
  - scl_oe=0, sda_oe=0 (bus released), busy=1, done=0, ack_error=0, reg_index=0.
  - State = PWRUP. The table is run automatically after every reset.
- States: IDLE, PWRUP, LOAD, START, SHIFT, ACK, STOP, GAP, DONE.
- PWRUP: count PWRUP_CYCLES, then go to LOAD.
- LOAD:
  - Fetch the table entry {addr[7:0], data[15:0]} at reg_index.
  - Form a 4-byte shift frame: DEV_ADDR, addr, data[15:8], data[7:0].
  - Byte counter = 0, then go to START.
- START, 4 quarters: SDA high with SCL high → SDA low (q1) → SCL low (q3).
- SHIFT, 8 bits MSB first, 4 quarters per bit:
  - q0: set SDA while SCL is low.
  - q1: release SCL.
  - q3: pull SCL low.
- ACK, one bit:
  - Release SDA and release SCL.
  - Sample sda_in at the end of q2, while SCL is high.
  - sda_in=0 → ACK. If more bytes remain, go to SHIFT; else go to STOP.
  - sda_in=1 → set an internal nack flag and go to STOP.
- STOP: SDA low with SCL low → release SCL (q1) → release SDA (q3).
- After STOP:
  - If nack is set: go to DONE with ack_error=1, done=0.
  - Otherwise, if reg_index==NUM_REGS-1: go to DONE with done=1.
  - Otherwise: go to GAP.
- GAP: count GAP_CYCLES, increment reg_index, go to LOAD.
- DONE:
  - busy=0; done and ack_error hold their values.
  - A start pulse clears done and ack_error, sets reg_index=0 and busy=1, then goes to LOAD with no power-up delay.
- IDLE is entered only from DONE and behaves identically. It is reserved for a later read-back extension.
- Timing:
  - The quarter-phase counter counts 0..QTR-1. Every state change occurs at a quarter boundary.
  - One write = START + 36 bit-times + STOP = 38 bit-times = 380 µs at 100 kHz.
- Clock stretching is not supported; a slave holding SCL low is ignored.
- Reset asserted mid-transaction:
  - The next cycle releases both lines and returns to PWRUP.
  - The slave sees SDA rise while SCL is released, which acts as a STOP.
- scl_oe and sda_oe are registered, with no combinational path from sda_in.

Decomposition:
- Shared package mt9d111_pkg holds:
  - MT9D111_DEV_ADDR = 8'hBA;
  - register address constants (page select 0xF0, output format, context/size registers);
  - the table entry width, 24.
- Sub-module mt9d111_config_rom:
  - combinational lookup index → {addr, data}, NUM_REGS entries;
  - entry 0 = {0xF0, 0x0001} (page select).
  - Keeping the table in its own module allows retuning without touching the sequencer.

Test Plan:
- Reset, then an ACKing slave model → no SCL edge before cycle 50000. First frame decoded as BA, F0, 00, 01 with four ACKs. done=1 after 16 writes and busy=0.
- SCL period check → SCL high 250 cycles and low 250 cycles (±0). START has SDA falling while SCL is high; STOP has SDA rising while SCL is high.
- Slave NACKs the second byte of entry 3 → STOP issued immediately, ack_error=1, done=0, reg_index=3, and no further START.
- start pulse in DONE after the NACK → ack_error clears and the sequence restarts at entry 0 without the 50000-cycle delay. done=1 at the end.
- start pulse while busy → ignored; the transaction and byte stream are unchanged.
- reset asserted during bit 5 of byte 2 → scl_oe=0 and sda_oe=0 the next cycle, state PWRUP. The full sequence then replays from entry 0.

Source files
------------

// File: rtl/mt9d111_pkg.sv
// Shared types and constants for the MT9D111 configuration path.
package mt9d111_pkg;

  // 7-bit sensor address 0x5D followed by the write bit.
  localparam logic [7:0] MT9D111_DEV_ADDR = 8'hBA;

  // Sensor registers used by the configuration table.
  localparam logic [7:0] REG_PAGE_SEL = 8'hF0;  // register page select
  localparam logic [7:0] REG_OUT_FMT  = 8'h97;  // output format configuration
  localparam logic [7:0] REG_MCU_ADDR = 8'hC6;  // MCU variable address (context/size vars)
  localparam logic [7:0] REG_MCU_DATA = 8'hC8;  // MCU variable data

  // One table entry is {register address, 16-bit data}.
  localparam int ENTRY_W = 24;
  // One bus frame is {device address, register address, data high, data low}.
  localparam int FRAME_W = 32;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_LOAD,
    ST_START,
    ST_SHIFT,
    ST_ACK,
    ST_STOP,
    ST_GAP,
    ST_DONE
  } state_e;

  // Build the 4-byte MSB-first shift frame for one register write.
  function automatic logic [FRAME_W-1:0] make_frame(input logic [7:0]         dev,
                                                    input logic [ENTRY_W-1:0] entry);
    return {dev, entry};
  endfunction

endpackage

// File: rtl/mt9d111_config_rom.sv
// Register table that puts the MT9D111 into 320x240 YCbCr 4:2:2 output.
module mt9d111_config_rom
  import mt9d111_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0]   index_i,
  output logic [ENTRY_W-1:0] entry_o
);

  // Index to {addr, data} lookup; unused indices read as zero.
  always_comb begin
    entry_o = '0;
    case (index_i)
      IDX_W'(0):  entry_o = {REG_PAGE_SEL, 16'h0001};  // page 1 (IFP/MCU)
      IDX_W'(1):  entry_o = {REG_OUT_FMT,  16'h0000};  // YCbCr, no swaps
      IDX_W'(2):  entry_o = {REG_MCU_ADDR, 16'h2703};  // context A output width
      IDX_W'(3):  entry_o = {REG_MCU_DATA, 16'h0140};  // 320
      IDX_W'(4):  entry_o = {REG_MCU_ADDR, 16'h2705};  // context A output height
      IDX_W'(5):  entry_o = {REG_MCU_DATA, 16'h00F0};  // 240
      IDX_W'(6):  entry_o = {REG_MCU_ADDR, 16'h2707};  // context B output width
      IDX_W'(7):  entry_o = {REG_MCU_DATA, 16'h0140};  // 320
      IDX_W'(8):  entry_o = {REG_MCU_ADDR, 16'h2709};  // context B output height
      IDX_W'(9):  entry_o = {REG_MCU_DATA, 16'h00F0};  // 240
      IDX_W'(10): entry_o = {REG_MCU_ADDR, 16'h2755};  // context A output format
      IDX_W'(11): entry_o = {REG_MCU_DATA, 16'h0000};  // YCbCr 4:2:2
      IDX_W'(12): entry_o = {REG_MCU_ADDR, 16'h2757};  // context B output format
      IDX_W'(13): entry_o = {REG_MCU_DATA, 16'h0000};  // YCbCr 4:2:2
      IDX_W'(14): entry_o = {REG_MCU_ADDR, 16'hA103};  // sequencer command
      IDX_W'(15): entry_o = {REG_MCU_DATA, 16'h0005};  // refresh mode
      default:    entry_o = '0;
    endcase
  end

endmodule

// File: rtl/mt9d111_i2c_config.sv
// Power-up I2C sequencer: walks the register table and writes each entry to
// the MT9D111. Bus lines are open-drain; the *_oe outputs only pull low.
module mt9d111_i2c_config
  import mt9d111_pkg::*;
#(
  parameter int         CLK_HZ       = 50000000,
  parameter int         I2C_HZ       = 100000,
  parameter logic [7:0] DEV_ADDR     = MT9D111_DEV_ADDR,
  parameter int         NUM_REGS     = 16,
  parameter int         PWRUP_CYCLES = 50000,
  parameter int         GAP_CYCLES   = 500,
  parameter int         IDX_W        = $clog2(NUM_REGS)
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             start,
  output logic             scl_oe,
  output logic             sda_oe,
  input  logic             sda_in,
  output logic             busy,
  output logic             done,
  output logic             ack_error,
  output logic [IDX_W-1:0] reg_index
);

  localparam int QTR     = CLK_HZ / (4 * I2C_HZ);
  localparam int QW      = (QTR > 1) ? $clog2(QTR) : 1;
  localparam int DLY_MAX = (PWRUP_CYCLES > GAP_CYCLES) ? PWRUP_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(DLY_MAX + 1);

  localparam logic [QW-1:0]    QTR_LAST   = QW'(QTR - 1);
  localparam logic [CW-1:0]    PWRUP_LAST = CW'(PWRUP_CYCLES - 1);
  localparam logic [CW-1:0]    GAP_LAST   = CW'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_REGS - 1);

  state_e             state_q;
  logic [QW-1:0]      qcnt_q;     // cycle within the current quarter bit
  logic [1:0]         quarter_q;  // quarter within the current bit
  logic [CW-1:0]      dly_q;      // power-up / inter-write delay counter
  logic [2:0]         bit_q;
  logic [1:0]         byte_q;
  logic [FRAME_W-1:0] frame_q;
  logic               nack_q;
  logic               scl_oe_q;
  logic               sda_oe_q;
  logic               busy_q;
  logic               done_q;
  logic               ack_error_q;
  logic [IDX_W-1:0]   reg_index_q;

  logic [ENTRY_W-1:0] entry_s;
  logic [FRAME_W-1:0] frame_d;
  logic [QW-1:0]      qcnt_d;
  logic               qtick_s;

  mt9d111_config_rom #(
    .IDX_W(IDX_W)
  ) u_rom (
    .index_i(reg_index_q),
    .entry_o(entry_s)
  );

  assign frame_d = make_frame(DEV_ADDR, entry_s);
  assign qtick_s = (qcnt_q == QTR_LAST);
  assign qcnt_d  = qtick_s ? '0 : qcnt_q + QW'(1);

  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_error = ack_error_q;
  assign reg_index = reg_index_q;

  // Sequencer: all line changes are applied at quarter boundaries and take
  // effect for the quarter being entered, so both lines stay registered.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state_q     <= ST_PWRUP;
      qcnt_q      <= '0;
      quarter_q   <= 2'd0;
      dly_q       <= '0;
      bit_q       <= 3'd0;
      byte_q      <= 2'd0;
      frame_q     <= '0;
      nack_q      <= 1'b0;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      ack_error_q <= 1'b0;
      reg_index_q <= '0;
    end else begin
      case (state_q)
        ST_PWRUP: begin
          qcnt_q <= '0;
          if (dly_q == PWRUP_LAST) begin
            dly_q   <= '0;
            state_q <= ST_LOAD;
          end else begin
            dly_q <= dly_q + CW'(1);
          end
        end

        // One quarter with the bus idle while the frame is latched.
        ST_LOAD: begin
          frame_q   <= frame_d;
          byte_q    <= 2'd0;
          bit_q     <= 3'd0;
          nack_q    <= 1'b0;
          quarter_q <= 2'd0;
          qcnt_q    <= qcnt_d;
          if (qtick_s) begin
            state_q <= ST_START;
          end else begin
            state_q <= ST_LOAD;
          end
        end

        ST_START: begin
          qcnt_q <= qcnt_d;
          if (qtick_s) begin
            quarter_q <= quarter_q + 2'd1;
            case (quarter_q)
              2'd0: sda_oe_q <= 1'b1;          // SDA falls, SCL high
              2'd2: scl_oe_q <= 1'b1;          // SCL low
              2'd3: begin
                state_q  <= ST_SHIFT;
                bit_q    <= 3'd0;
                sda_oe_q <= ~frame_q[FRAME_W-1];
              end
              default: ;
            endcase
          end
        end

        ST_SHIFT: begin
          qcnt_q <= qcnt_d;
          if (qtick_s) begin
            quarter_q <= quarter_q + 2'd1;
            case (quarter_q)
              2'd0: scl_oe_q <= 1'b0;
              2'd2: scl_oe_q <= 1'b1;
              2'd3: begin
                frame_q <= {frame_q[FRAME_W-2:0], 1'b0};
                if (bit_q == 3'd7) begin
                  state_q  <= ST_ACK;
                  sda_oe_q <= 1'b0;            // hand SDA to the slave
                end else begin
                  bit_q    <= bit_q + 3'd1;
                  sda_oe_q <= ~frame_q[FRAME_W-2];
                end
              end
              default: ;
            endcase
          end
        end

        ST_ACK: begin
          qcnt_q <= qcnt_d;
          if (qtick_s) begin
            quarter_q <= quarter_q + 2'd1;
            case (quarter_q)
              2'd0: scl_oe_q <= 1'b0;
              2'd2: begin
                nack_q   <= sda_in;            // sampled at end of q2, SCL high
                scl_oe_q <= 1'b1;
              end
              2'd3: begin
                if (nack_q || (byte_q == 2'd3)) begin
                  state_q  <= ST_STOP;
                  sda_oe_q <= 1'b1;
                end else begin
                  state_q  <= ST_SHIFT;
                  byte_q   <= byte_q + 2'd1;
                  bit_q    <= 3'd0;
                  sda_oe_q <= ~frame_q[FRAME_W-1];
                end
              end
              default: ;
            endcase
          end
        end

        ST_STOP: begin
          qcnt_q <= qcnt_d;
          if (qtick_s) begin
            quarter_q <= quarter_q + 2'd1;
            case (quarter_q)
              2'd0: scl_oe_q <= 1'b0;
              2'd2: sda_oe_q <= 1'b0;          // SDA rises, SCL high
              2'd3: begin
                dly_q <= '0;
                if (nack_q) begin
                  state_q     <= ST_DONE;
                  ack_error_q <= 1'b1;
                  busy_q      <= 1'b0;
                end else if (reg_index_q == IDX_LAST) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                end else begin
                  state_q <= ST_GAP;
                end
              end
              default: ;
            endcase
          end
        end

        ST_GAP: begin
          qcnt_q <= '0;
          if (dly_q == GAP_LAST) begin
            dly_q       <= '0;
            reg_index_q <= reg_index_q + IDX_W'(1);
            state_q     <= ST_LOAD;
          end else begin
            dly_q <= dly_q + CW'(1);
          end
        end

        ST_DONE, ST_IDLE: begin
          qcnt_q <= '0;
          if (start) begin
            done_q      <= 1'b0;
            ack_error_q <= 1'b0;
            reg_index_q <= '0;
            busy_q      <= 1'b1;
            dly_q       <= '0;
            state_q     <= ST_LOAD;
          end else begin
            busy_q <= 1'b0;
          end
        end

        default: begin
          state_q  <= ST_PWRUP;
          scl_oe_q <= 1'b0;
          sda_oe_q <= 1'b0;
          busy_q   <= 1'b1;
          dly_q    <= '0;
          qcnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mt9d111_i2c_config.sv
// Bench for mt9d111_i2c_config with a bus-level slave model. Timing
// parameters are scaled (quarter = 4 cycles, short delays) to keep runs short.
module tb_mt9d111_i2c_config;
  import mt9d111_pkg::*;

  localparam int QTR_TB   = 4;
  localparam int PWRUP_TB = 1000;
  localparam int GAP_TB   = 16;

  logic       clk_50 = 1'b0;
  logic       reset;
  logic       start;
  logic       scl_oe, sda_oe, sda_in;
  logic       busy, done, ack_error;
  logic [3:0] reg_index;

  mt9d111_i2c_config #(
    .CLK_HZ      (50000000),
    .I2C_HZ      (3125000),
    .NUM_REGS    (16),
    .PWRUP_CYCLES(PWRUP_TB),
    .GAP_CYCLES  (GAP_TB)
  ) dut (
    .clk_50   (clk_50),
    .reset    (reset),
    .start    (start),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe),
    .sda_in   (sda_in),
    .busy     (busy),
    .done     (done),
    .ack_error(ack_error),
    .reg_index(reg_index)
  );

  always #10 clk_50 = ~clk_50;

  // ---------------- slave model / bus monitor ----------------
  logic       ack_drive = 1'b0;
  logic       scl_b, sda_b;
  assign scl_b  = ~scl_oe;
  assign sda_b  = ~sda_oe & ~ack_drive;
  assign sda_in = sda_b;

  logic       prev_scl = 1'b1, prev_sda = 1'b1;
  logic       in_ack = 1'b0, hi_valid = 1'b0;
  logic [7:0] shreg = 8'h00;
  int cyc = 0, starts = 0, stops = 0, nbytes = 0, cur_frame = 0;
  int bitcnt = 0, bytenum = 0, rise_cyc = 0, fall_cyc = 0;
  int hi_min = 1000000, hi_max = 0, lo_min = 1000000, lo_max = 0;
  logic [7:0] log_b [0:1023];
  int         frame_pos [0:127];
  int         nack_frame, nack_byte;   // driven by the stimulus process

  // Decode START/STOP/bits on the open-drain bus and answer with ACK/NACK.
  always @(negedge clk_50) begin
    cyc      <= cyc + 1;
    prev_scl <= scl_b;
    prev_sda <= sda_b;
    if (scl_b && prev_scl && prev_sda && !sda_b) begin
      frame_pos[starts] <= nbytes;
      cur_frame <= starts;
      starts    <= starts + 1;
      bitcnt    <= 0;
      bytenum   <= 0;
      in_ack    <= 1'b0;
      hi_valid  <= 1'b0;
      ack_drive <= 1'b0;
    end else if (scl_b && prev_scl && !prev_sda && sda_b) begin
      stops <= stops + 1;
    end else if (scl_b && !prev_scl) begin
      rise_cyc <= cyc;
      hi_valid <= 1'b1;
      if (cyc - fall_cyc < lo_min) lo_min <= cyc - fall_cyc;
      if (cyc - fall_cyc > lo_max) lo_max <= cyc - fall_cyc;
      if (bitcnt < 8) begin
        shreg  <= {shreg[6:0], sda_b};
        bitcnt <= bitcnt + 1;
      end
    end else if (!scl_b && prev_scl) begin
      fall_cyc <= cyc;
      if (hi_valid) begin
        if (cyc - rise_cyc < hi_min) hi_min <= cyc - rise_cyc;
        if (cyc - rise_cyc > hi_max) hi_max <= cyc - rise_cyc;
      end
      if (bitcnt == 8 && !in_ack) begin
        log_b[nbytes] <= shreg;
        nbytes        <= nbytes + 1;
        in_ack        <= 1'b1;
        ack_drive     <= !(cur_frame == nack_frame && bytenum == nack_byte);
      end else if (bitcnt == 8 && in_ack) begin
        ack_drive <= 1'b0;
        in_ack    <= 1'b0;
        bitcnt    <= 0;
        bytenum   <= bytenum + 1;
      end
    end
  end

  // ---------------- checking ----------------
  typedef struct {
    int          idx;
    logic [7:0]  addr;
    logic [15:0] data;
  } vec_t;
  vec_t vecs [16];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_50);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_not_busy(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk("busy_clear_within_budget", {31'd0, busy}, 32'd0);
  endtask

  // Compare 16 frames starting at monitor frame s0 against the vector table.
  task automatic check_run(input int s0);
    for (int k = 0; k < 16; k++) begin
      int f, p, len;
      logic [31:0] got;
      f   = s0 + k;
      p   = frame_pos[f];
      len = ((f + 1) < starts) ? (frame_pos[f + 1] - p) : (nbytes - p);
      chk($sformatf("frame%0d_len", vecs[k].idx), len, 32'd4);
      got = {log_b[p], log_b[p + 1], log_b[p + 2], log_b[p + 3]};
      chk($sformatf("frame%0d_bytes", vecs[k].idx), got,
          {8'hBA, vecs[k].addr, vecs[k].data});
    end
  endtask

  initial begin
    int s0, st0, n, ri;
    vecs[0]  = '{0,  8'hF0, 16'h0001};
    vecs[1]  = '{1,  8'h97, 16'h0000};
    vecs[2]  = '{2,  8'hC6, 16'h2703};
    vecs[3]  = '{3,  8'hC8, 16'h0140};
    vecs[4]  = '{4,  8'hC6, 16'h2705};
    vecs[5]  = '{5,  8'hC8, 16'h00F0};
    vecs[6]  = '{6,  8'hC6, 16'h2707};
    vecs[7]  = '{7,  8'hC8, 16'h0140};
    vecs[8]  = '{8,  8'hC6, 16'h2709};
    vecs[9]  = '{9,  8'hC8, 16'h00F0};
    vecs[10] = '{10, 8'hC6, 16'h2755};
    vecs[11] = '{11, 8'hC8, 16'h0000};
    vecs[12] = '{12, 8'hC6, 16'h2757};
    vecs[13] = '{13, 8'hC8, 16'h0000};
    vecs[14] = '{14, 8'hC6, 16'hA103};
    vecs[15] = '{15, 8'hC8, 16'h0005};

    nack_frame = -1;
    nack_byte  = -1;
    reset = 1'b1;
    start = 1'b0;
    repeat (5) tick();

    // Reset state
    chk("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ack_error", {31'd0, ack_error}, 32'd0);
    chk("rst_reg_index", {28'd0, reg_index}, 32'd0);

    // Run A: power-up delay, full table, a start pulse while busy
    s0  = starts;
    st0 = stops;
    reset = 1'b0;
    n = 0;
    while (!scl_oe && n < 3000) begin
      tick();
      n++;
    end
    chk("pwrup_no_scl_before_delay", {31'd0, (n >= PWRUP_TB)}, 32'd1);
    chk("pwrup_first_scl_not_late", {31'd0, (n <= PWRUP_TB + 40)}, 32'd1);
    repeat (3000) tick();
    ri = reg_index;
    pulse_start();
    chk("busy_start_still_busy", {31'd0, busy}, 32'd1);
    chk("busy_start_index_kept", {28'd0, reg_index}, ri);
    wait_not_busy(20000);
    chk("runA_done", {31'd0, done}, 32'd1);
    chk("runA_ack_error", {31'd0, ack_error}, 32'd0);
    chk("runA_reg_index", {28'd0, reg_index}, 32'd15);
    chk("runA_starts", starts - s0, 32'd16);
    chk("runA_stops", stops - st0, 32'd16);
    check_run(s0);
    chk("scl_high_min", hi_min, 2 * QTR_TB);
    chk("scl_high_max", hi_max, 2 * QTR_TB);
    chk("scl_low_min", lo_min, 2 * QTR_TB);
    chk("scl_low_max", lo_max, 2 * QTR_TB);

    // Run B: NACK on the second byte of entry 3
    s0  = starts;
    st0 = stops;
    nack_frame = s0 + 3;
    nack_byte  = 1;
    pulse_start();
    chk("runB_done_cleared", {31'd0, done}, 32'd0);
    chk("runB_busy", {31'd0, busy}, 32'd1);
    wait_not_busy(10000);
    chk("nack_ack_error", {31'd0, ack_error}, 32'd1);
    chk("nack_done", {31'd0, done}, 32'd0);
    chk("nack_reg_index", {28'd0, reg_index}, 32'd3);
    chk("nack_starts", starts - s0, 32'd4);
    chk("nack_stops", stops - st0, 32'd4);
    chk("nack_frame_len", nbytes - frame_pos[s0 + 3], 32'd2);
    chk("nack_frame_bytes", {16'd0, log_b[frame_pos[s0 + 3]], log_b[frame_pos[s0 + 3] + 1]},
        32'h0000BAC8);
    repeat (2000) tick();
    chk("nack_no_more_start", starts - s0, 32'd4);
    chk("nack_bus_released", {30'd0, scl_oe, sda_oe}, 32'd0);

    // Run C: restart from DONE, no power-up delay
    nack_frame = -1;
    s0 = starts;
    pulse_start();
    chk("restart_ack_error_cleared", {31'd0, ack_error}, 32'd0);
    chk("restart_reg_index", {28'd0, reg_index}, 32'd0);
    n = 0;
    while (!scl_oe && n < 3000) begin
      tick();
      n++;
    end
    chk("restart_without_pwrup", {31'd0, (n < 100)}, 32'd1);
    wait_not_busy(20000);
    chk("runC_done", {31'd0, done}, 32'd1);
    chk("runC_ack_error", {31'd0, ack_error}, 32'd0);
    check_run(s0);

    // Run D: reset during bit 5 of byte 2, then full replay
    s0 = starts;
    pulse_start();
    n = 0;
    while (!(starts > s0 && bytenum == 2 && bitcnt == 5) && n < 5000) begin
      tick();
      n++;
    end
    chk("midreset_reached_bit5_byte2", {31'd0, (n < 5000)}, 32'd1);
    reset = 1'b1;
    tick();
    chk("midreset_scl_released", {31'd0, scl_oe}, 32'd0);
    chk("midreset_sda_released", {31'd0, sda_oe}, 32'd0);
    chk("midreset_busy", {31'd0, busy}, 32'd1);
    chk("midreset_state_pwrup", 32'(dut.state_q), 32'(ST_PWRUP));
    tick();
    s0 = starts;
    reset = 1'b0;
    wait_not_busy(20000);
    chk("runD_done", {31'd0, done}, 32'd1);
    chk("runD_reg_index", {28'd0, reg_index}, 32'd15);
    check_run(s0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard stop in case anything above stalls.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
